// File: rtl/servant_timer_arm.sv
// Periodic timer re-arm engine.
// Reads mtime over a Wishbone initiator port, writes mtimecmp = mtime + period,
// then waits for the synchronised timer interrupt, pulses o_tick and repeats.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_en              run the re-arm loop while high
//   i_period          tick period, low WIDTH bits used, clamped to MIN_PERIOD
//   i_irq             timer compare interrupt (asynchronous)
//   o_wb_cyc/we/dat   Wishbone initiator request (cyc doubles as strobe)
//   i_wb_dat/ack      Wishbone read data and acknowledge
//   o_tick, o_ticks   expiry pulse and 16-bit wrapping expiry count
//   o_err             one-cycle pulse when a bus cycle times out
module servant_timer_arm #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned MIN_PERIOD  = 16,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [31:0] i_period,
    input  logic        i_irq,
    output logic        o_wb_cyc,
    output logic        o_wb_we,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    output logic        o_tick,
    output logic [15:0] o_ticks,
    output logic        o_err
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_CLR,
        S_ARM
    } state_t;

    state_t             state_q, state_d;
    logic               rdy_q, rdy_d;
    logic               sync1_q, sync1_d;
    logic               irq_s_q, irq_s_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [WIDTH-1:0]   dat_q, dat_d;
    logic               tick_q, tick_d;
    logic [15:0]        ticks_q, ticks_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   period_w;
    logic [WIDTH-1:0]   period_clamped;
    logic [WIDTH-1:0]   cmp_sum;
    logic               ack_v;
    logic               unused_bits;

    // Only the low WIDTH bits of the 32-bit bus fields carry information.
    assign unused_bits = ^{i_wb_dat, i_period};

    // Compare value: mtime + clamped period, wrapping modulo 2^WIDTH.
    always_comb begin
        period_w       = i_period[WIDTH-1:0];
        period_clamped = (32'(period_w) < 32'(MIN_PERIOD)) ? WIDTH'(MIN_PERIOD) : period_w;
        cmp_sum        = i_wb_dat[WIDTH-1:0] + period_clamped;
    end

    // An acknowledge only counts while a bus cycle is open.
    assign ack_v = i_wb_ack & cyc_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        rdy_d   = 1'b1;
        sync1_d = i_irq;
        irq_s_d = sync1_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        dat_d   = dat_q;
        tick_d  = 1'b0;
        ticks_d = ticks_q;
        err_d   = 1'b0;
        cnt_d   = '0;

        case (state_q)
            S_IDLE: begin
                cyc_d = 1'b0;
                we_d  = 1'b0;
                // rdy_q delays the first read by one edge after reset release.
                if (rdy_q && i_en) begin
                    state_d = S_RD;
                    cyc_d   = 1'b1;
                end
            end
            S_RD: begin
                if (ack_v) begin
                    state_d = S_WR;
                    we_d    = 1'b1;
                    dat_d   = cmp_sum;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR: begin
                if (ack_v) begin
                    state_d = i_en ? S_CLR : S_IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CLR: begin
                // Let the interrupt from the previous compare drain first.
                if (!i_en) begin
                    state_d = S_IDLE;
                end else if (!irq_s_q) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (!i_en) begin
                    state_d = S_IDLE;
                end else if (irq_s_q) begin
                    state_d = S_RD;
                    tick_d  = 1'b1;
                    ticks_d = ticks_q + 16'd1;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            sync1_q <= 1'b0;
            irq_s_q <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            dat_q   <= '0;
            tick_q  <= 1'b0;
            ticks_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            sync1_q <= sync1_d;
            irq_s_q <= irq_s_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            dat_q   <= dat_d;
            tick_q  <= tick_d;
            ticks_q <= ticks_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_wb_cyc = cyc_q;
    assign o_wb_we  = we_q;
    assign o_wb_dat = 32'(dat_q);
    assign o_tick   = tick_q;
    assign o_ticks  = ticks_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_servant_timer_arm.sv
// Directed bench for servant_timer_arm (default parameters).
module tb_servant_timer_arm;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] period;
    logic        irq;
    logic        cyc;
    logic        we;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        tick;
    logic [15:0] ticks;
    logic        err;

    int total = 0;
    int bad   = 0;
    int exp_ticks = 0;

    typedef struct {
        logic [31:0] mtime;
        logic [31:0] per;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    servant_timer_arm dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_en     (en),
        .i_period (period),
        .i_irq    (irq),
        .o_wb_cyc (cyc),
        .o_wb_we  (we),
        .o_wb_dat (wb_dat_o),
        .i_wb_dat (wb_dat_i),
        .i_wb_ack (wb_ack),
        .o_tick   (tick),
        .o_ticks  (ticks),
        .o_err    (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input string name);
        int n = 0;
        while (cyc !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, " cyc up"}, 32'(cyc), 32'd1);
    endtask

    // One read/write pair; period is scrambled after RD exit to prove it was sampled.
    task automatic do_xfer(input string name, input logic [31:0] mt,
                           input logic [31:0] per, input logic [31:0] exp_dat);
        wait_cyc(name);
        chk({name, " rd we"}, 32'(we), 32'd0);
        period   = per;
        wb_dat_i = mt;
        wb_ack   = 1'b1;
        @(negedge clk);
        wb_ack   = 1'b0;
        period   = 32'hDEAD_0007;
        wb_dat_i = 32'hFFFF_FFFF;
        chk({name, " wr cyc"}, 32'(cyc), 32'd1);
        chk({name, " wr we"}, 32'(we), 32'd1);
        chk({name, " wr dat"}, wb_dat_o, exp_dat);
        @(negedge clk);
        chk({name, " wr hold"}, wb_dat_o, exp_dat);
        wb_ack = 1'b1;
        @(negedge clk);
        wb_ack = 1'b0;
        chk({name, " cyc drop"}, 32'(cyc), 32'd0);
    endtask

    // Five-cycle irq pulse issued while ARM is reached; expect one tick 3 edges later.
    task automatic do_irq(input string name);
        int first = -1;
        int cnt   = 0;
        irq = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
            if (k == 5) irq = 1'b0;
        end
        exp_ticks++;
        chk({name, " tick count"}, 32'(cnt), 32'd1);
        chk({name, " tick delay"}, 32'(first), 32'd3);
        chk({name, " ticks"}, 32'(ticks), 32'(exp_ticks));
        chk({name, " new rd"}, 32'(cyc), 32'd1);
    endtask

    // Watch for any tick or bus activity over n cycles.
    task automatic quiet(input string name, input int n);
        int seen_tick = 0;
        int seen_cyc  = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (tick === 1'b1) seen_tick++;
            if (cyc === 1'b1) seen_cyc++;
        end
        chk({name, " no tick"}, 32'(seen_tick), 32'd0);
        chk({name, " no cyc"}, 32'(seen_cyc), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0010, 32'd100,       32'h0000_0074};
        vecs[1] = '{32'h0000_FFF0, 32'h0000_0020, 32'h0000_0010};
        vecs[2] = '{32'h0000_1234, 32'd3,         32'h0000_1244};
        vecs[3] = '{32'h0000_0000, 32'd16,        32'h0000_0010};
        vecs[4] = '{32'hABCD_8000, 32'hFFFF_0005, 32'h0000_8010};
        vecs[5] = '{32'h0000_FFFF, 32'h0001_0011, 32'h0000_0010};
        vecs[6] = '{32'h0000_0100, 32'd15,        32'h0000_0110};

        rst = 1'b1; en = 1'b0; irq = 1'b0; wb_ack = 1'b0;
        period = '0; wb_dat_i = '0;
        repeat (3) @(negedge clk);
        chk("reset cyc", 32'(cyc), 32'd0);
        chk("reset we", 32'(we), 32'd0);
        chk("reset dat", wb_dat_o, 32'd0);
        chk("reset tick", 32'(tick), 32'd0);
        chk("reset ticks", 32'(ticks), 32'd0);
        chk("reset err", 32'(err), 32'd0);

        en  = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("release edge1 cyc", 32'(cyc), 32'd0);
        @(negedge clk);
        chk("release edge2 cyc", 32'(cyc), 32'd1);

        for (int i = 0; i < 7; i++) begin
            do_xfer($sformatf("vec%0d", i), vecs[i].mtime, vecs[i].per, vecs[i].exp_dat);
            do_irq($sformatf("irq%0d", i));
        end

        // Enable dropped in CLR/ARM: back to IDLE, irq ignored.
        do_xfer("pre_idle", 32'h0000_0300, 32'h0000_0050, 32'h0000_0350);
        en  = 1'b0;
        irq = 1'b1;
        quiet("en_off", 6);
        irq = 1'b0;
        repeat (3) @(negedge clk);

        // Ack withheld in RD: timeout, then retry; ack while idle is ignored.
        en = 1'b1;
        @(negedge clk);
        chk("to cyc start", 32'(cyc), 32'd1);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 14) begin
                chk("to k14 cyc", 32'(cyc), 32'd1);
                chk("to k14 err", 32'(err), 32'd0);
            end
            if (k == 15) begin
                chk("to k15 cyc", 32'(cyc), 32'd0);
                chk("to k15 err", 32'(err), 32'd1);
                wb_ack = 1'b1;
            end
            if (k == 16) begin
                wb_ack = 1'b0;
                chk("to k16 err", 32'(err), 32'd0);
                chk("to retry cyc", 32'(cyc), 32'd1);
                chk("to retry we", 32'(we), 32'd0);
            end
            if (k == 17) begin
                chk("to idle ack ignored we", 32'(we), 32'd0);
            end
        end

        // Enable dropped during WR: write completes on ack, then IDLE.
        period   = 32'h0000_0040;
        wb_dat_i = 32'h0000_0200;
        wb_ack   = 1'b1;
        @(negedge clk);
        wb_ack = 1'b0;
        chk("enwr we", 32'(we), 32'd1);
        chk("enwr dat", wb_dat_o, 32'h0000_0240);
        en = 1'b0;
        @(negedge clk);
        chk("enwr still wr", 32'(cyc), 32'd1);
        wb_ack = 1'b1;
        @(negedge clk);
        wb_ack = 1'b0;
        chk("enwr cyc drop", 32'(cyc), 32'd0);
        quiet("enwr idle", 4);

        // Stale interrupt still high after the write: CLR must wait for it to clear.
        en = 1'b1;
        @(negedge clk);
        chk("stale rd cyc", 32'(cyc), 32'd1);
        irq      = 1'b1;
        period   = 32'h0000_0020;
        wb_dat_i = 32'h0000_1000;
        wb_ack   = 1'b1;
        @(negedge clk);
        wb_ack = 1'b1;
        chk("stale wr dat", wb_dat_o, 32'h0000_1020);
        @(negedge clk);
        wb_ack = 1'b0;
        chk("stale cyc drop", 32'(cyc), 32'd0);
        quiet("stale hold", 6);
        irq = 1'b0;
        quiet("stale drain", 4);
        do_irq("post_stale");

        // Reset while RD is open: everything clears without a clock edge.
        #1;
        rst = 1'b1;
        #1;
        chk("rst rd cyc", 32'(cyc), 32'd0);
        chk("rst rd we", 32'(we), 32'd0);
        chk("rst rd dat", wb_dat_o, 32'd0);
        chk("rst rd tick", 32'(tick), 32'd0);
        chk("rst rd ticks", 32'(ticks), 32'd0);
        chk("rst rd err", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
